// File: rtl/scan_8seg_if.sv
// -----------------------------------------------------------------------------
// scan_8seg_if
// Write bus from the MCS51 bus glue into the scan_8seg digit register file.
//   wr     : write strobe, one cycle per write
//   addr   : digit index being written
//   wdata  : [3:0] tetrade, [4] dot, [5] digit enable, [7:6] unused
// master modport drives the bus (bus glue / testbench), slave receives it.
// -----------------------------------------------------------------------------
interface scan_8seg_if;
    logic       wr;
    logic [2:0] addr;
    logic [7:0] wdata;

    modport master (output wr, addr, wdata);
    modport slave  (input  wr, addr, wdata);
endinterface

// File: rtl/scan_8seg.sv
// -----------------------------------------------------------------------------
// scan_8seg
// Time-multiplexed scan controller for a bank of 8-segment digits sharing one
// decode_8seg decoder. Digit contents are double-buffered: the bus writes a
// shadow copy, and the whole shadow set is copied to the live set at the end
// of each frame, so a frame never mixes old and new contents. Each digit slot
// starts with BLANK guard cycles (no digit selected) to suppress ghosting.
//
// Parameters
//   DIGITS : digits scanned (2..8)
//   SLOT   : clock cycles per digit slot (BLANK+1..65536)
//   BLANK  : guard cycles at the start of each slot (1..SLOT-1)
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : write bus (wr, addr, wdata), slave side
//   blank     : global blank request, level, registered before use
//   oe        : decoder output enable
//   tetrade   : decoder tetrade input
//   dot       : decoder dot input
//   digit_sel : one-hot digit drive, bit i = digit i
//   frame     : one-cycle pulse at the start of each frame
// -----------------------------------------------------------------------------
module scan_8seg #(
    parameter int DIGITS = 4,
    parameter int SLOT   = 1024,
    parameter int BLANK  = 16
) (
    input  logic              clk,
    input  logic              rst,
    scan_8seg_if.slave        bus,
    input  logic              blank,
    output logic              oe,
    output logic [3:0]        tetrade,
    output logic              dot,
    output logic [DIGITS-1:0] digit_sel,
    output logic              frame
);

    localparam int CW = $clog2(SLOT);
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    // Field layout matches wdata[5:0] so a write is a straight cast.
    typedef struct packed {
        logic       en;
        logic       dot;
        logic [3:0] tetrade;
    } digit_t;

    typedef enum logic {
        PH_GUARD,
        PH_ACTIVE
    } phase_t;

    digit_t            shadow [DIGITS];
    digit_t            live   [DIGITS];
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic              blank_q;

    logic [DIGITS-1:0] wr_hit;
    digit_t            wr_entry;
    logic              commit;
    phase_t            phase;
    digit_t            cur;

    // wdata[7:6] carry nothing for this block.
    logic [1:0]        unused_wdata;
    assign unused_wdata = bus.wdata[7:6];

    assign wr_entry = digit_t'(bus.wdata[5:0]);
    // Last cycle of the last digit slot: the frame boundary.
    assign commit   = (cnt == CNT_LAST) && (idx == IDX_LAST);

    // Address decode; addresses at or above DIGITS match no digit and are dropped.
    always_comb begin
        // NOTE: default every combinational output before any conditional
        // assignment so no path leaves it unassigned and infers a latch.
        wr_hit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.wr && (bus.addr == 3'(i))) begin
                wr_hit[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            blank_q <= 1'b0;
            // NOTE: the register file is a handful of flops, not a RAM macro,
            // so it is cleared with the rest of the state; a display must come
            // up dark rather than showing power-up garbage.
            for (int i = 0; i < DIGITS; i++) begin
                shadow[i] <= '0;
                live[i]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the pre-edge value of every other one (the commit
            // below reads the old shadow, not the one being written).
            blank_q <= blank;

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            for (int i = 0; i < DIGITS; i++) begin
                // A write landing on the commit edge goes straight into the
                // new frame, bypassing the shadow copy it would otherwise miss.
                if (commit) begin
                    live[i] <= wr_hit[i] ? wr_entry : shadow[i];
                end
                if (wr_hit[i]) begin
                    shadow[i] <= wr_entry;
                end
            end
        end
    end

    // Outputs decode registered state only; no input reaches an output
    // without passing through a flop.
    assign phase = (cnt < CNT_BLANK) ? PH_GUARD : PH_ACTIVE;
    assign cur   = live[idx];

    always_comb begin
        digit_sel = '0;
        oe        = 1'b0;
        // Data stays driven in GUARD and for disabled digits; the decoder
        // blanks via oe.
        tetrade   = cur.tetrade;
        dot       = cur.dot;
        if (phase == PH_ACTIVE) begin
            digit_sel[idx] = 1'b1;
            oe             = cur.en & ~blank_q;
        end
    end

    assign frame = (cnt == '0) && (idx == '0);

endmodule

// File: tb/tb_scan_8seg.sv
// -----------------------------------------------------------------------------
// tb_scan_8seg
// Bench for scan_8seg with DIGITS=4, SLOT=8, BLANK=2 (frame = 32 cycles).
// A time-based model (cycles since reset -> digit/slot position) plus
// per-digit shadow/live contents predicts every output each cycle; directed
// literal expectations pin key points of the scan.
// -----------------------------------------------------------------------------
module tb_scan_8seg;

    localparam int DIGITS = 4;
    localparam int SLOT   = 8;
    localparam int BLANK  = 2;
    localparam int FRAME  = DIGITS * SLOT;

    logic              clk;
    logic              rst;
    logic              blank;
    logic              oe;
    logic [3:0]        tetrade;
    logic              dot;
    logic [DIGITS-1:0] digit_sel;
    logic              frame;

    scan_8seg_if bus ();

    scan_8seg #(
        .DIGITS (DIGITS),
        .SLOT   (SLOT),
        .BLANK  (BLANK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .blank     (blank),
        .oe        (oe),
        .tetrade   (tetrade),
        .dot       (dot),
        .digit_sel (digit_sel),
        .frame     (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    int         m_t;            // clock edges since reset released
    logic [5:0] m_shadow [DIGITS];
    logic [5:0] m_live   [DIGITS];
    logic       m_bq;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t  <= 0;
            m_bq <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                m_shadow[i] <= 6'd0;
                m_live[i]   <= 6'd0;
            end
        end else begin
            // Frame boundary: the new frame shows the latest written values.
            if (m_t % FRAME == FRAME - 1) begin
                for (int i = 0; i < DIGITS; i++) begin
                    m_live[i] <= (bus.wr && int'(bus.addr) == i) ? bus.wdata[5:0] : m_shadow[i];
                end
            end
            if (bus.wr && int'(bus.addr) < DIGITS) begin
                m_shadow[bus.addr[1:0]] <= bus.wdata[5:0];
            end
            m_t  <= m_t + 1;
            m_bq <= blank;
        end
    end

    function automatic logic [10:0] model_out();
        int         d;
        int         c;
        logic       act;
        logic [5:0] e;
        logic [3:0] sel;
        d   = (m_t % FRAME) / SLOT;
        c   = m_t % SLOT;
        act = (c >= BLANK);
        e   = m_live[d];
        sel = act ? 4'(1 << d) : 4'd0;
        return {act & e[5] & ~m_bq, e[3:0], e[4], sel, (m_t % FRAME) == 0};
    endfunction

    logic check_en = 1'b0;

    always @(negedge clk) begin
        if (check_en) begin
            check($sformatf("cycle t=%0d", m_t), {21'd0, oe, tetrade, dot, digit_sel, frame},
                  {21'd0, model_out()});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_out(input string name, input logic e_oe, input logic [3:0] e_tet,
                              input logic e_dot, input logic [3:0] e_sel, input logic e_frame);
        check(name, {21'd0, oe, tetrade, dot, digit_sel, frame},
              {21'd0, e_oe, e_tet, e_dot, e_sel, e_frame});
    endtask

    // Advance to just after the negedge at which the model reaches cycle target.
    task automatic wait_t(input int target);
        int guard = 0;
        while (m_t != target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (m_t != target) begin
            total++;
            bad++;
            $display("FAIL wait_t: reached t=%0d expected t=%0d", m_t, target);
        end
    endtask

    // Present a write so that it lands on the edge that produces cycle t_land.
    task automatic write_at(input int t_land, input logic [2:0] a, input logic [7:0] d);
        wait_t(t_land - 1);
        bus.wr    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        wait_t(t_land);
        bus.wr    = 1'b0;
        bus.addr  = 3'd0;
        bus.wdata = 8'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        blank     = 1'b0;
        bus.wr    = 1'b0;
        bus.addr  = 3'd0;
        bus.wdata = 8'd0;
        repeat (2) @(negedge clk);
        #1;
        expect_out("reset state", 1'b0, 4'h0, 1'b0, 4'b0000, 1'b1);
        rst      = 1'b0;
        check_en = 1'b1;

        // Idle scan: guard/active pattern, frame every 32 cycles, oe low.
        wait_t(1);  expect_out("idle t1 guard",   1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
        wait_t(2);  expect_out("idle t2 d0",      1'b0, 4'h0, 1'b0, 4'b0001, 1'b0);
        wait_t(10); expect_out("idle t10 d1",     1'b0, 4'h0, 1'b0, 4'b0010, 1'b0);
        wait_t(26); expect_out("idle t26 d3",     1'b0, 4'h0, 1'b0, 4'b1000, 1'b0);
        wait_t(32); expect_out("idle frame t32",  1'b0, 4'h0, 1'b0, 4'b0000, 1'b1);
        wait_t(34); expect_out("idle t34 d0",     1'b0, 4'h0, 1'b0, 4'b0001, 1'b0);

        // Write digit 2 mid-frame: invisible until the frame after the commit.
        write_at(69, 3'd2, 8'h3A);
        wait_t(82);  expect_out("d2 before commit", 1'b0, 4'h0, 1'b0, 4'b0100, 1'b0);
        wait_t(96);  expect_out("frame t96",        1'b0, 4'h0, 1'b0, 4'b0000, 1'b1);
        wait_t(112); expect_out("d2 guard",         1'b0, 4'hA, 1'b1, 4'b0000, 1'b0);
        wait_t(114); expect_out("d2 shown",         1'b1, 4'hA, 1'b1, 4'b0100, 1'b0);

        // Write landing exactly on the commit edge is in the next frame.
        write_at(128, 3'd1, 8'h25);
        wait_t(138); expect_out("d1 commit-edge write", 1'b1, 4'h5, 1'b0, 4'b0010, 1'b0);

        // Out-of-range address is ignored; fill digits 0 and 3.
        write_at(140, 3'd5, 8'h3F);
        write_at(145, 3'd0, 8'h21);
        write_at(150, 3'd3, 8'h37);
        wait_t(162); expect_out("d0 shown",           1'b1, 4'h1, 1'b0, 4'b0001, 1'b0);
        wait_t(170); expect_out("d1 kept after addr5", 1'b1, 4'h5, 1'b0, 4'b0010, 1'b0);

        // Global blank: one register stage on assert and release.
        wait_t(202); expect_out("pre-blank d1", 1'b1, 4'h5, 1'b0, 4'b0010, 1'b0);
        blank = 1'b1;
        wait_t(203); expect_out("blanked d1",   1'b0, 4'h5, 1'b0, 4'b0010, 1'b0);
        wait_t(213); expect_out("blanked d2",   1'b0, 4'hA, 1'b1, 4'b0100, 1'b0);
        blank = 1'b0;
        wait_t(214); expect_out("unblanked d2", 1'b1, 4'hA, 1'b1, 4'b0100, 1'b0);

        // Asynchronous reset mid-ACTIVE of digit 3.
        wait_t(250); expect_out("d3 shown", 1'b1, 4'h7, 1'b1, 4'b1000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("async reset", 1'b0, 4'h0, 1'b0, 4'b0000, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        wait_t(1);  expect_out("post-reset guard", 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0);
        wait_t(2);  expect_out("post-reset d0",    1'b0, 4'h0, 1'b0, 4'b0001, 1'b0);
        wait_t(10); expect_out("post-reset d1",    1'b0, 4'h0, 1'b0, 4'b0010, 1'b0);
        wait_t(40);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_8seg.md
# scan_8seg

Time-multiplexed scan controller for a common-anode/common-cathode bank of 8-segment digits driven through a single shared `decode_8seg` decoder. It holds a double-buffered per-digit register file written from the MCS51 bus glue. It cycles one digit at a time with a guard (blanking) interval between digits to suppress ghosting. Per digit it drives the decoder's `oe`, `tetrade` and `dot` inputs plus a one-hot digit-select bus.

## Interface
- `DIGITS`, 4: number of digits scanned, legal 2..8.
- `SLOT`, 1024: clock cycles per digit slot, legal BLANK+1..65536.
- `BLANK`, 16: guard cycles at the start of each slot, legal 1..SLOT-1.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `wr`  in  1  write strobe, one cycle per write.
- `addr`  in  3  digit index for write; `addr` >= DIGITS ignored.
- `wdata`  in  8  [3:0] tetrade, [4] dot, [5] digit enable, [7:6] ignored.
- `blank`  in  1  global blank request, level.
- `oe`  out  1  to decoder `oe`.
- `tetrade`  out  4  to decoder `tetrade`.
- `dot`  out  1  to decoder `dot`.
- `digit_sel`  out  DIGITS  one-hot digit drive, bit i = digit i.
- `frame`  out  1  one-cycle pulse at the start of each frame.

## Operation
- Registers: `shadow[i]` and `live[i]`, each 6 bits. Also `idx` (digit counter, 0..DIGITS-1), `cnt` (slot counter, 0..SLOT-1) and `blank_q` (registered `blank`).
- Writes: `wr` with `addr` < DIGITS loads `wdata[5:0]` into `shadow[addr]` on that edge. Writes never touch `live` directly.
- Commit: on the edge where `cnt`==SLOT-1 and `idx`==DIGITS-1, every `live[i]` loads `shadow[i]`.
  - A write to digit i on the commit edge is included in the commit (`live[i]` gets the written value).
  - Result: a frame never displays a mix of old and new contents.
- Scan: `cnt` increments every cycle and wraps SLOT-1 -> 0. On the wrap, `idx` increments, and wraps DIGITS-1 -> 0.
- Two phases, derived from `cnt`:
  - GUARD: `cnt` < BLANK. `digit_sel`=0, `oe`=0.
  - ACTIVE: `cnt` >= BLANK. `digit_sel` = one-hot(`idx`); `oe` = `live[idx]`[5] & ~`blank_q`; `tetrade` = `live[idx]`[3:0]; `dot` = `live[idx]`[4].
- When `oe`=0, `tetrade` and `dot` are still driven from `live[idx]`. The decoder blanks the segments.
- A disabled digit (enable=0) keeps its `digit_sel` bit asserted in ACTIVE, with `oe`=0. Scan timing is unchanged: no digit skipping.
- `frame` = 1 exactly when `cnt`==0 and `idx`==0.
- Frame period = DIGITS*SLOT cycles.

## Timing
- All outputs are decoded combinationally from registered state only. There is no combinational path from any input to any output.
- `blank` takes effect on the cycle after it is sampled (one register stage). Releasing it restores `oe` one cycle later, mid-slot if in ACTIVE.
- Write latency to display: the write lands in `shadow` on edge N. It becomes visible from the first ACTIVE cycle of the target digit in the frame after the next commit.
- Reset (asynchronous, any time, including mid-slot or mid-write):
  - `shadow`, `live`, `idx`, `cnt` and `blank_q` all go to 0 immediately.
  - Outputs: `oe`=0, `tetrade`=0, `dot`=0, `digit_sel`=0, and `frame`=1 (state `cnt`=0, `idx`=0).
  - A `wr` coincident with reset is lost.
- First post-reset edge: `cnt`=1; the first ACTIVE cycle is at `cnt`=BLANK of digit 0.
- Every digit transition contains at least BLANK cycles with `digit_sel`=0. Two `digit_sel` bits are never high together.

## Test plan
All scenarios use DIGITS=4, SLOT=8, BLANK=2.
- Reset then idle 64 cycles -> `frame` pulses every 32 cycles. `digit_sel` sequence per slot: 0,0,0001×6, then 0,0,0010×6, and so on. `oe` is always 0.
- Write `addr`=2, `wdata`=0x3A at cycle 5 -> frame 0 digit 2 shows `oe`=0. From frame 1, in digit 2 `cnt` 2..7: `oe`=1, `tetrade`=0xA, `dot`=1, `digit_sel`=0100.
- Write `addr`=1, `wdata`=0x25 exactly on the commit edge -> digit 1 shows `tetrade`=5, `oe`=1 in the immediately following frame.
- Write `addr`=5, `wdata`=0x3F -> no register changes; all digits keep their prior contents.
- Digits 0..3 enabled, `blank`=1 for cycles 10..20 -> `oe`=0 from cycle 11 through 21. `digit_sel` scanning is unaffected.
- Assert `rst` asynchronously mid-ACTIVE of digit 3 with live data -> in the same cycle, outputs are 0 (`frame`=1) and contents are cleared. Scanning restarts at digit 0 GUARD.
